// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D single-port RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

    localparam int unsigned ARB_RD_LAT_DEF = 1;
    localparam int unsigned ARB_STARVE_DEF = 4;
    localparam int unsigned ARB_LAT_W      = 2;
    localparam int unsigned ARB_STARVE_W   = 4;
    localparam int unsigned ARB_SEL_W      = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side I/D ports plus the unified RAM command/response bus.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import mem_arbiter_pkg::*;

    logic                 i_req;
    logic [ADDR_W-1:0]    i_addr;
    logic                 i_gnt;
    logic                 i_rvalid;
    logic [DATA_W-1:0]    i_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [ARB_SEL_W-1:0] d_sel;
    logic [ADDR_W-1:0]    d_addr;
    logic [DATA_W-1:0]    d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [DATA_W-1:0]    d_rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ARB_SEL_W-1:0] mem_sel;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_sel, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_sel, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select: D has fixed priority unless I has been denied STARVE_MAX cycles in a row.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = ARB_STARVE_DEF
) (
    input  logic clk,
    input  logic _rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_allowed,
    output logic i_win,
    output logic d_win
);

    logic [ARB_STARVE_W-1:0] starve_q, starve_d;
    logic                    starved;

    assign starved = (starve_q == ARB_STARVE_W'(STARVE_MAX));
    assign i_win   = grant_allowed & i_req & (~d_req | starved);
    assign d_win   = grant_allowed & d_req & ~i_win;

    // Counts every denied I cycle, whether lost to D or blocked by an outstanding read.
    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_win) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + ARB_STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and data ports,
// one transaction in flight, with a new grant allowed on the read-response cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = ARB_RD_LAT_DEF,
    parameter int unsigned STARVE_MAX = ARB_STARVE_DEF
) (
    input  logic          clk,
    input  logic          _rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    logic [ARB_LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic                 resp_q, resp_d;

    logic grant_allowed;
    logic i_win, d_win;
    logic i_rvalid_c, d_rvalid_c;

    // resp_q marks the cycle the RAM presents read data; a new grant may overlap it.
    assign grant_allowed = _rst & ((state_q == ARB_IDLE) | resp_q);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk           (clk),
        ._rst          (_rst),
        .i_req         (bus.i_req),
        .d_req         (bus.d_req),
        .grant_allowed (grant_allowed),
        .i_win         (i_win),
        .d_win         (d_win)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        resp_d    = 1'b0;

        if (state_q == ARB_WAIT) begin
            if (lat_cnt_q != '0) begin
                lat_cnt_d = lat_cnt_q - ARB_LAT_W'(1);
                resp_d    = (lat_cnt_q == ARB_LAT_W'(1));
            end else begin
                state_d = ARB_IDLE;
            end
        end

        if (i_win || d_win) begin
            owner_d = d_win ? ARB_OWN_D : ARB_OWN_I;
            if (i_win || !bus.d_we) begin
                state_d   = ARB_WAIT;
                lat_cnt_d = ARB_LAT_W'(RD_LAT - 1);
                resp_d    = (RD_LAT == 1);
            end else begin
                state_d   = ARB_IDLE;
                lat_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= ARB_OWN_I;
            lat_cnt_q <= '0;
            resp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            resp_q    <= resp_d;
        end
    end

    // RAM command is driven straight from the winner in the grant cycle.
    always_comb begin
        bus.mem_en    = i_win | d_win;
        bus.mem_we    = 1'b0;
        bus.mem_sel   = '0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        if (d_win) begin
            bus.mem_we    = bus.d_we;
            bus.mem_sel   = bus.d_sel;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (i_win) begin
            bus.mem_sel   = 4'hF;
            bus.mem_addr  = bus.i_addr;
        end
    end

    assign i_rvalid_c   = resp_q & (owner_q == ARB_OWN_I);
    assign d_rvalid_c   = resp_q & (owner_q == ARB_OWN_D);

    assign bus.i_gnt    = i_win;
    assign bus.d_gnt    = d_win;
    assign bus.i_rvalid = i_rvalid_c;
    assign bus.d_rvalid = d_rvalid_c;
    assign bus.i_rdata  = i_rvalid_c ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.d_rdata  = d_rvalid_c ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port (I, read-only) and data port (D, read/write with byte select).
- Sits between the core and the unified memory, replacing the separate instruction and data memories.
- D has fixed priority; a starvation counter guarantees I forward progress.
- One transaction is outstanding at a time; grants can issue back-to-back on the response cycle.

Parameters:
- ADDR_W, 32, address width (matches `DATA_ADDR_WIDTH / `INST_ADDR_WIDTH).
- DATA_W, 32, data width (matches `DATA_WIDTH).
- RD_LAT, 1, RAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, consecutive denied I-request cycles before I takes priority; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- _rst  in  1  reset; asynchronous assert, active-low.
- i_req  in  1  I request; held with i_addr stable until i_gnt.
- i_addr  in  ADDR_W  I read address.
- i_gnt  out  1  I request accepted this cycle (combinational).
- i_rvalid  out  1  I read data valid (registered).
- i_rdata  out  DATA_W  I read data; equals mem_rdata when i_rvalid, else 0.
- d_req  in  1  D request; held with its fields stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_sel  in  4  byte enables for writes.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  D write data.
- d_gnt  out  1  D request accepted this cycle (combinational).
- d_rvalid  out  1  D read data valid (registered).
- d_rdata  out  DATA_W  D read data; equals mem_rdata when d_rvalid, else 0.
- mem_en  out  1  RAM command strobe.
- mem_we  out  1  RAM write enable.
- mem_sel  out  4  RAM byte enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid RD_LAT cycles after the command.

Behaviour:
- Reset (_rst=0, any time): state IDLE, owner cleared, latency counter 0, starve counter 0. All outputs 0. An in-flight read is discarded with no rvalid after release.
- States:
  - IDLE: may grant.
  - WAIT: read outstanding; lat_cnt counts RD_LAT-1 down to 0.
- Issuing a grant is allowed in IDLE, and in WAIT on the cycle the response is delivered.
- On a grant in cycle T:
  - Exactly one of i_gnt/d_gnt is high.
  - mem_en=1 and mem_addr/mem_we/mem_sel/mem_wdata are driven from the winner in the same cycle. I reads: we=0, sel=4'hF, wdata=0.
  - When no grant is issued: mem_en=0 and all other mem_* are 0.
- Read granted at T: response (rvalid high one cycle for the owner) at T+RD_LAT. State is WAIT for cycles T+1..T+RD_LAT. A new grant may issue at T+RD_LAT; otherwise return to IDLE.
- Write granted at T: no rvalid. Completion = d_gnt. The next grant may issue at T+1.
- RD_LAT=1: one read per cycle sustained.
- Arbitration when both request:
  - D wins unless starve_cnt==STARVE_MAX, in which case I wins.
  - A single requester always wins when a grant is allowed.
- starve_cnt (4-bit):
  - Increments when i_req=1 and i_gnt=0 (blocked by D or by WAIT).
  - Saturates at STARVE_MAX.
  - Clears on i_gnt or when i_req=0.
- Owner tag is registered at grant. rvalid routes only to the owner's port; the other port's rdata stays 0.
- Simultaneous response and new grant: rvalid goes to the old owner and the gnt to the new winner in the same cycle; the owner tag updates at the edge.
- d_sel=0 on a write is legal: the cycle is consumed with mem_sel=0.
- Address alignment is not checked.

Decomposition:
- Shared defines in cpu_property.v:
  - ARB_IDLE/ARB_WAIT state encodings.
  - ARB_OWN_I/ARB_OWN_D owner encodings.
  - Default latency constant.
- One natural sub-module: mem_arb_prio. It holds starve_cnt plus the winner-select logic, takes i_req, d_req and grant_allowed, and produces i_win and d_win.

Test Plan:
- Reset then i_req=1 (i_addr=0x100), RD_LAT=1 → i_gnt at T, mem_addr=0x100, mem_en=1, i_rvalid at T+1 with i_rdata=mem_rdata; d_rdata=0.
- d_req write (0x200, 0xDEADBEEF, sel=4'b0011) together with i_req → d_gnt first with mem_we=1 and mem_sel=0011; i_gnt the next cycle.
- d_req held continuously with reads, i_req held, STARVE_MAX=4 → i_gnt on the 5th contended grant opportunity; starve_cnt then clears.
- RD_LAT=3, D read granted at T → mem_en low at T+1..T+2, d_rvalid at T+3, pending i_req granted at T+3.
- Back-to-back I reads at RD_LAT=1 for 8 cycles → 8 consecutive i_gnt pulses and 8 i_rvalid pulses with matching addresses/data.
- _rst low at T+1 after a read grant at T (RD_LAT=2) → all outputs 0 immediately; no rvalid after release; IDLE.
